// File: rtl/wc_tile_streamer_pkg.sv
// Shared widths, FSM encoding and tile/result containers for the Winograd tile streamer.
package wc_tile_streamer_pkg;

  localparam int DW       = 10;
  localparam int TILE_IN  = 6;
  localparam int TILE_OUT = 3;
  localparam int CORE_LAT = 6;

  localparam int FILL_W = $clog2(TILE_IN + 1);
  localparam int CNT_W  = $clog2(CORE_LAT + 1);
  localparam int IDX_W  = $clog2(TILE_OUT);

  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_e;

  typedef logic [DW-1:0]        smp_t;
  typedef smp_t [TILE_IN-1:0]  tile_t;
  typedef smp_t [TILE_OUT-1:0] res_t;

  // Load request from the streamer FSM into the result serializer.
  typedef struct packed {
    logic load;
    logic fin;
    res_t res;
  } ser_req_t;

endpackage

// File: rtl/wc_tile_streamer_if.sv
// Sample-in / result-out valid-ready bus of the tile streamer.
interface wc_tile_streamer_if;
  import wc_tile_streamer_pkg::*;

  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;

  modport slave  (input  s_data, s_valid, s_last, m_ready,
                  output s_ready, m_data, m_valid, m_last);
  modport master (output s_data, s_valid, s_last, m_ready,
                  input  s_ready, m_data, m_valid, m_last);

endinterface

// File: rtl/wc_res_serializer.sv
// Holds one tile's core results and returns them one per accepted beat, oldest first.
module wc_res_serializer
  import wc_tile_streamer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  ser_req_t      req,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic          done
);

  res_t             res_q;
  logic [IDX_W-1:0] idx_q;
  logic             vld_q;
  logic             fin_q;
  logic             last_beat;

  assign last_beat = (idx_q == IDX_W'(TILE_OUT - 1));
  assign m_valid   = vld_q;
  assign m_data    = vld_q ? res_q[idx_q] : '0;
  assign m_last    = vld_q && fin_q && last_beat;
  assign done      = vld_q && m_ready && last_beat;

  // Registers only move on load or an accepted beat, so m_data/m_last hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (req.load) begin
      res_q <= req.res;
      idx_q <= '0;
      vld_q <= 1'b1;
      fin_q <= req.fin;
    end else if (vld_q && m_ready) begin
      if (last_beat) begin
        vld_q <= 1'b0;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wc_tile_streamer.sv
// Forms overlapping 6-sample tiles (stride 3) for the wc core, waits its latency, and
// streams the 3 results back out.
module wc_tile_streamer
  import wc_tile_streamer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  wc_tile_streamer_if.slave      bus,
  output logic [TILE_IN*DW-1:0]  core_d,
  input  logic [TILE_OUT*DW-1:0] core_z,
  output logic                   busy
);

  state_e            state, state_nxt;
  tile_t             smp_q, tile_q, tile_nxt, keep;
  res_t              z_res;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              final_q;
  logic              rdy_q;
  logic              accept, complete, lat_done, drain_done;
  ser_req_t          req;

  assign bus.s_ready = rdy_q && (state == FILL);
  assign accept      = bus.s_valid && bus.s_ready;
  assign complete    = accept && (bus.s_last || (fill_q == FILL_W'(TILE_IN - 1)));
  assign lat_done    = (state == HOLD) && (cnt_q == CNT_W'(CORE_LAT));
  assign busy        = (state != FILL) || (fill_q != '0);

  // Slot view: below fill keeps the buffer, at fill takes the incoming sample, above is zero pad.
  for (genvar i = 0; i < TILE_IN; i++) begin : g_slot
    localparam logic [FILL_W-1:0] SLOT = FILL_W'(i);
    assign tile_nxt[i] = (SLOT < fill_q)  ? smp_q[i]   :
                         (SLOT == fill_q) ? bus.s_data : '0;
    if (i < TILE_IN - TILE_OUT) begin : g_keep
      assign keep[i] = smp_q[i + TILE_OUT];
    end else begin : g_zero
      assign keep[i] = '0;
    end
    assign core_d[(TILE_IN - i)*DW-1 -: DW] = tile_q[i];
  end

  for (genvar j = 0; j < TILE_OUT; j++) begin : g_res
    assign z_res[j] = core_z[(TILE_OUT - j)*DW-1 -: DW];
  end

  assign req.load = lat_done;
  assign req.fin  = final_q;
  assign req.res  = z_res;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (complete)   state_nxt = HOLD;
      HOLD:    if (lat_done)   state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = FILL;
      default:                 state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      smp_q   <= '0;
      tile_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      final_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
      unique case (state)
        FILL: if (accept) begin
          smp_q  <= tile_nxt;
          fill_q <= fill_q + 1'b1;
          if (complete) begin
            tile_q  <= tile_nxt;
            final_q <= bus.s_last;
            cnt_q   <= '0;
          end
        end
        HOLD: cnt_q <= cnt_q + 1'b1;
        // Overlap: a continuing frame reuses the newest half of the tile as the next oldest half.
        DRAIN: if (drain_done) begin
          smp_q  <= final_q ? '0 : keep;
          fill_q <= final_q ? '0 : FILL_W'(TILE_IN - TILE_OUT);
        end
        default: ;
      endcase
    end
  end

  wc_res_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .m_data  (bus.m_data),
    .m_valid (bus.m_valid),
    .m_last  (bus.m_last),
    .m_ready (bus.m_ready),
    .done    (drain_done)
  );

endmodule

// File: tb/tb_wc_tile_streamer.sv
// Random and directed frames through the streamer, with a latency-accurate wc core model
// and a frame-level reference that derives tiles and results from the sample list.
module tb_wc_tile_streamer;

  typedef struct packed {
    logic [9:0] d;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [59:0] core_d;
  logic [29:0] core_z;
  logic        busy;

  wc_tile_streamer_if bus();

  wc_tile_streamer dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .core_d (core_d),
    .core_z (core_z),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int gap_pct = 0;
  int mready_pct = 100;
  int mlo_cnt = 0;
  bit mlo_arm = 1'b0;
  bit acc_pend = 1'b0;
  bit hold_chk = 1'b0;
  logic [9:0] hold_d;
  logic       hold_l;
  int last_acc_cyc = 0;
  int first_mv_cyc = -1;
  logic [59:0] cd_snap = '0;
  int frm [0:15];
  beat_t src_q[$];
  beat_t exp_q[$];

  int t1v [6] = '{2, -10, 3, 4, -13, -18};
  int t2v [6] = '{-19, -6, 3, -9, -12, 11};
  int t3v [9] = '{2, -10, 3, 4, -13, -18, 1, 2, 3};
  int t4v [4] = '{5, -7, 9, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // wc core: y[k] = 4 d[k] + 11 d[k+2] + 9 d[k+3], wrapped to 10 bits, CORE_LAT-deep delay.
  function automatic logic [29:0] wc_ref(input logic [59:0] d);
    int v [6];
    int y;
    logic [29:0] r;
    for (int i = 0; i < 6; i++) v[i] = int'($signed(d[(6-i)*10-1 -: 10]));
    r = '0;
    for (int j = 0; j < 3; j++) begin
      y = 4*v[j] + 11*v[j+2] + 9*v[j+3];
      r[(3-j)*10-1 -: 10] = y[9:0];
    end
    return r;
  endfunction

  logic [29:0] zp [0:5];
  always @(posedge clk) begin
    zp[0] <= wc_ref(core_d);
    for (int i = 1; i < 6; i++) zp[i] <= zp[i-1];
  end
  assign core_z = zp[5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sx(input int n, input int i);
    return (i < n) ? frm[i] : 0;
  endfunction

  function automatic logic [59:0] pack6(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
    int v [6];
    logic [59:0] r;
    v = '{a, b, c, d, e, f};
    for (int i = 0; i < 6; i++) r[(6-i)*10-1 -: 10] = v[i][9:0];
    return r;
  endfunction

  // Frame of n samples -> tile k covers samples 3k..3k+5 (zero past n); tiles continue
  // while each brings at least one new sample. m_last only on the very last result.
  task automatic push_frame(input int n, input bit model);
    beat_t b;
    int    tiles;
    int    y;
    for (int i = 0; i < n; i++) begin
      b.d = frm[i][9:0];
      b.l = (i == n - 1);
      src_q.push_back(b);
    end
    if (model) begin
      tiles = (n <= 6) ? 1 : 1 + (n - 6 + 2) / 3;
      for (int t = 0; t < tiles; t++)
        for (int j = 0; j < 3; j++) begin
          y = 4*sx(n, 3*t+j) + 11*sx(n, 3*t+j+2) + 9*sx(n, 3*t+j+3);
          b.d = y[9:0];
          b.l = (t == tiles - 1) && (j == 2);
          exp_q.push_back(b);
        end
    end
  endtask

  task automatic push_exp(input int a, input int b, input int c);
    int v [3];
    beat_t e;
    v = '{a, b, c};
    for (int j = 0; j < 3; j++) begin
      e.d = v[j][9:0];
      e.l = (j == 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 5000), 64'd1);
    @(negedge clk);
  endtask

  // Driver and monitor: everything is decided at the falling edge for the next rising edge.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (!rst) begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      acc_pend    = 1'b0;
      hold_chk    = 1'b0;
    end else begin
      if (acc_pend) begin
        cur = src_q.pop_front();
        if (cur.l) begin
          last_acc_cyc = cyc;
          cd_snap      = core_d;
        end
        bus.s_valid = 1'b0;
      end
      if (!bus.s_valid && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        bus.s_valid = 1'b1;
        bus.s_data  = src_q[0].d;
        bus.s_last  = src_q[0].l;
      end
      acc_pend = bus.s_valid && bus.s_ready;

      if (hold_chk) begin
        chk("hold_valid", 64'(bus.m_valid), 64'd1);
        chk("hold_data", 64'(bus.m_data), 64'(hold_d));
        chk("hold_last", 64'(bus.m_last), 64'(hold_l));
      end
      if (bus.m_valid) begin
        chk("s_ready_drain", 64'(bus.s_ready), 64'd0);
        if (first_mv_cyc < 0) first_mv_cyc = cyc;
      end
      if (mlo_arm && bus.m_valid) begin
        mlo_cnt = 5;
        mlo_arm = 1'b0;
      end
      if (mlo_cnt > 0) begin
        bus.m_ready = 1'b0;
        mlo_cnt--;
      end else begin
        bus.m_ready = ($urandom_range(99) < mready_pct);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("extra_result", 64'(bus.m_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("m_data", 64'(bus.m_data), 64'(e.d));
          chk("m_last", 64'(bus.m_last), 64'(e.l));
        end
      end
      hold_chk = bus.m_valid && !bus.m_ready;
      hold_d   = bus.m_data;
      hold_l   = bus.m_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_m_last", 64'(bus.m_last), 64'd0);
    chk("rst_core_d", 64'(core_d), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_s_ready", 64'(bus.s_ready), 64'd1);

    // 1: single fresh tile, constants, latency
    gap_pct = 0; mready_pct = 100;
    for (int i = 0; i < 6; i++) frm[i] = t1v[i];
    push_frame(6, 1'b0);
    push_exp(77, -113, -293);
    first_mv_cyc = -1;
    wait_idle("t1_done");
    chk("t1_core_d", 64'(cd_snap), 64'(60'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110));
    chk("t1_latency", 64'(first_mv_cyc - last_acc_cyc), 64'd7);

    // 2: next frame starts from an empty buffer
    for (int i = 0; i < 6; i++) frm[i] = t2v[i];
    push_frame(6, 1'b0);
    push_exp(-124, -231, -21);
    wait_idle("t2_done");
    chk("t2_core_d", 64'(cd_snap), 64'(pack6(-19, -6, 3, -9, -12, 11)));

    // 3: overlapping tiles
    for (int i = 0; i < 9; i++) frm[i] = t3v[i];
    push_frame(9, 1'b1);
    wait_idle("t3_done");
    chk("t3_core_d", 64'(cd_snap), 64'(pack6(4, -13, -18, 1, 2, 3)));

    // 4: short frame, zero padding
    for (int i = 0; i < 4; i++) frm[i] = t4v[i];
    push_frame(4, 1'b1);
    wait_idle("t4_done");
    chk("t4_core_d", 64'(cd_snap), 64'(pack6(5, -7, 9, 1, 0, 0)));

    // 5: backpressure in DRAIN with input held valid
    for (int i = 0; i < 9; i++) frm[i] = int'($urandom_range(1023)) - 512;
    mlo_arm = 1'b1;
    push_frame(9, 1'b1);
    wait_idle("t5_done");

    // random frames, random gaps and backpressure
    gap_pct = 30; mready_pct = 70;
    for (int f = 0; f < 20; f++) begin
      n = int'($urandom_range(14, 1));
      for (int i = 0; i < n; i++) frm[i] = int'($urandom_range(1023)) - 512;
      push_frame(n, 1'b1);
    end
    wait_idle("rand_done");

    // 6: reset during DRAIN after result 0
    gap_pct = 0; mready_pct = 100;
    for (int i = 0; i < 6; i++) frm[i] = int'($urandom_range(1023)) - 512;
    push_frame(6, 1'b1);
    n = 0;
    while (exp_q.size() > 2 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_reach_drain", 64'(n < 500), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t6_m_valid", 64'(bus.m_valid), 64'd0);
    chk("t6_m_last", 64'(bus.m_last), 64'd0);
    chk("t6_m_data", 64'(bus.m_data), 64'd0);
    chk("t6_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_core_d", 64'(core_d), 64'd0);
    exp_q.delete();
    src_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_s_ready", 64'(bus.s_ready), 64'd1);
    for (int i = 0; i < 6; i++) frm[i] = int'($urandom_range(1023)) - 512;
    push_frame(6, 1'b1);
    wait_idle("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
